// File: rtl/servo_motion_scheduler_if.sv
// servo_motion_scheduler_if: command handshake bundle.
// master: cmd_valid/cmd_ch/cmd_pos out, cmd_ready/cmd_err in.
interface servo_motion_scheduler_if #(
  parameter int CH_W  = 2,
  parameter int POS_W = 7
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CH_W-1:0]  cmd_ch;
  logic [POS_W-1:0] cmd_pos;
  logic             cmd_err;

  modport master (
    output cmd_valid, cmd_ch, cmd_pos,
    input  cmd_ready, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_pos,
    output cmd_ready, cmd_err
  );
endinterface

// File: rtl/servo_motion_scheduler.sv
// servo_motion_scheduler: per-channel target store + framed ramp.
// Ports: clk, rst (sync high), cmd (slave bundle), pos_out, ch_en, busy, move_done.
module servo_motion_scheduler #(
  parameter int NUM_CH        = 4,
  parameter int POS_W         = 7,
  parameter int POS_MAX       = 100,
  parameter int POS_HOME      = 50,
  parameter int STEP_SIZE     = 5,
  parameter int UPDATE_CYCLES = 1_000_000,
  parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  servo_motion_scheduler_if.slave cmd,
  output logic [NUM_CH*POS_W-1:0] pos_out,
  output logic [NUM_CH-1:0]       ch_en,
  output logic                    busy,
  output logic                    move_done
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(UPDATE_CYCLES);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPDATE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
  localparam logic [POS_W-1:0] PMAX     = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] PHOME    = POS_W'(POS_HOME);
  localparam logic [POS_W:0]   STEP     = (POS_W+1)'(STEP_SIZE);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SWEEP = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] cur_q [NUM_CH];
  logic [POS_W-1:0] cur_d [NUM_CH];
  logic [POS_W-1:0] tgt_q [NUM_CH];
  logic [POS_W-1:0] tgt_d [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;
  logic flag_q, flag_d;
  logic err_q, err_d;
  logic done_q, done_d;

  logic             tick;
  logic             accept;
  logic             ch_ok;
  logic             flag_now;
  logic             busy_nxt;
  logic [CH_W-1:0]  ch;
  logic [POS_W-1:0] sat;

  // One bounded step toward t; the extra bit keeps differences exact.
  function automatic logic [POS_W-1:0] ramp(
    input logic [POS_W-1:0] c,
    input logic [POS_W-1:0] t
  );
    logic [POS_W:0] cw, tw, d, r;
    cw = {1'b0, c};
    tw = {1'b0, t};
    d  = '0;
    r  = cw;
    if (cw < tw) begin
      d = tw - cw;
      r = cw + ((d > STEP) ? STEP : d);
    end else if (cw > tw) begin
      d = cw - tw;
      r = cw - ((d > STEP) ? STEP : d);
    end
    return POS_W'(r);
  endfunction

  assign tick          = (cnt_q == CNT_LAST);
  assign cmd.cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign ch            = cmd.cmd_ch;
  assign ch_ok         = int'(ch) < NUM_CH;
  assign sat           = (cmd.cmd_pos > PMAX) ? PMAX : cmd.cmd_pos;
  assign cmd.cmd_err   = err_q;
  assign move_done     = done_q;
  assign ch_en         = en_q;

  always_comb begin
    pos_out = '0;
    busy    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      pos_out[k*POS_W +: POS_W] = cur_q[k];
      busy = busy | (en_q[k] && (cur_q[k] != tgt_q[k]));
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    cur_d    = cur_q;
    tgt_d    = tgt_q;
    en_d     = en_q;
    flag_d   = flag_q;
    err_d    = 1'b0;
    done_d   = 1'b0;
    flag_now = flag_q;
    busy_nxt = 1'b0;

    // Commands are only taken in IDLE, so they never race the sweep.
    if (accept) begin
      if (!ch_ok) begin
        err_d = 1'b1;
      end else begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (ch == CH_W'(k)) begin
            tgt_d[k] = sat;
            if (!en_q[k]) begin
              cur_d[k] = sat;
              en_d[k]  = 1'b1;
            end
          end
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_SWEEP;
          idx_d   = '0;
        end
      end
      S_SWEEP: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (idx_q == IDX_W'(k) && en_q[k]) begin
            cur_d[k] = ramp(cur_q[k], tgt_q[k]);
          end
        end
        // busy sampled before the first channel moves.
        if (idx_q == '0) begin
          flag_now = busy;
        end
        flag_d = flag_now;
        for (int k = 0; k < NUM_CH; k++) begin
          busy_nxt = busy_nxt | (en_d[k] && (cur_d[k] != tgt_d[k]));
        end
        if (idx_q == IDX_LAST) begin
          state_d = S_IDLE;
          idx_d   = '0;
          done_d  = flag_now && !busy_nxt;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        cur_q[k] <= PHOME;
        tgt_q[k] <= PHOME;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
      done_q  <= done_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule

// File: tb/tb_servo_motion_scheduler.sv
// tb_servo_motion_scheduler: scoreboard bench for the motion scheduler.
// Snapshot changes are popped against a queue of expected snapshots.
module tb_servo_motion_scheduler;

  typedef logic [34:0] snap_t;

  logic        clk;
  logic        rst;
  logic [27:0] pos_out;
  logic [3:0]  ch_en;
  logic        busy;
  logic        move_done;

  int n_checks = 0;
  int n_pass   = 0;

  snap_t exp_q[$];

  servo_motion_scheduler_if #(.CH_W(3), .POS_W(7)) bus ();

  servo_motion_scheduler #(
    .NUM_CH(4),
    .POS_W(7),
    .POS_MAX(100),
    .POS_HOME(50),
    .STEP_SIZE(5),
    .UPDATE_CYCLES(10),
    .CH_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd(bus),
    .pos_out(pos_out),
    .ch_en(ch_en),
    .busy(busy),
    .move_done(move_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t mk(
    input int p0, input int p1, input int p2, input int p3,
    input logic [3:0] en, input logic b,
    input logic md, input logic err
  );
    return {7'(p3), 7'(p2), 7'(p1), 7'(p0), en, b, md, err};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got %0d expected %0d", name, got, want);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s got timeout expected event", name);
  endtask

  task automatic wait_ready(input logic v, input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.cmd_ready === v) return;
    end
    timeout(name);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    timeout(name);
  endtask

  task automatic send(input logic [2:0] c, input logic [6:0] p);
    bit ok;
    ok = 0;
    bus.cmd_ch    = c;
    bus.cmd_pos   = p;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (bus.cmd_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout("send_ready");
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every visible output change consumes one expectation.
  initial begin
    snap_t prev, now, e;
    prev = '1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      now = {pos_out, ch_en, busy, move_done, bus.cmd_err};
      if (now !== prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_change got %h expected none", now);
        end else begin
          e = exp_q.pop_front();
          if (now === e) n_pass++;
          else $display("FAIL snapshot got %h expected %h", now, e);
        end
        prev = now;
      end
    end
  end

  initial begin
    int lows;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_ch    = '0;
    bus.cmd_pos   = '0;

    // Reset state
    exp_q.push_back(mk(50, 50, 50, 50, 4'b0000, 0, 0, 0));
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.cmd_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.cmd_ready), 1);

    // First enable: no ramp
    exp_q.push_back(mk(80, 50, 50, 50, 4'b0001, 0, 0, 0));
    send(3'd0, 7'd80);
    wait_drain("drain_enable");

    // Ramp up 80 -> 93
    exp_q.push_back(mk(80, 50, 50, 50, 4'b0001, 1, 0, 0));
    exp_q.push_back(mk(85, 50, 50, 50, 4'b0001, 1, 0, 0));
    exp_q.push_back(mk(90, 50, 50, 50, 4'b0001, 1, 0, 0));
    exp_q.push_back(mk(93, 50, 50, 50, 4'b0001, 0, 0, 0));
    exp_q.push_back(mk(93, 50, 50, 50, 4'b0001, 0, 1, 0));
    exp_q.push_back(mk(93, 50, 50, 50, 4'b0001, 0, 0, 0));
    send(3'd0, 7'd93);
    wait_drain("drain_up");

    // Ramp down 93 -> 81
    exp_q.push_back(mk(93, 50, 50, 50, 4'b0001, 1, 0, 0));
    exp_q.push_back(mk(88, 50, 50, 50, 4'b0001, 1, 0, 0));
    exp_q.push_back(mk(83, 50, 50, 50, 4'b0001, 1, 0, 0));
    exp_q.push_back(mk(81, 50, 50, 50, 4'b0001, 0, 0, 0));
    exp_q.push_back(mk(81, 50, 50, 50, 4'b0001, 0, 1, 0));
    exp_q.push_back(mk(81, 50, 50, 50, 4'b0001, 0, 0, 0));
    send(3'd0, 7'd81);
    wait_drain("drain_down");

    // Saturation on first enable
    exp_q.push_back(mk(81, 100, 50, 50, 4'b0011, 0, 0, 0));
    send(3'd1, 7'd120);
    wait_drain("drain_sat");

    // Out-of-range channel
    exp_q.push_back(mk(81, 100, 50, 50, 4'b0011, 0, 0, 1));
    exp_q.push_back(mk(81, 100, 50, 50, 4'b0011, 0, 0, 0));
    send(3'd5, 7'd7);
    wait_drain("drain_err");

    // Hold valid across a sweep
    wait_ready(1'b1, "hold_idle");
    wait_ready(1'b0, "hold_sweep");
    exp_q.push_back(mk(81, 100, 60, 50, 4'b0111, 0, 0, 0));
    bus.cmd_ch    = 3'd2;
    bus.cmd_pos   = 7'd60;
    bus.cmd_valid = 1'b1;
    lows = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      lows++;
    end
    chk("sweep_ready_low", 32'(lows), 4);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    wait_drain("drain_hold");

    // Command on the tick cycle lands before the sweep
    wait_ready(1'b0, "tick_sweep");
    wait_ready(1'b1, "tick_idle");
    repeat (5) @(negedge clk);
    exp_q.push_back(mk(81, 100, 60, 50, 4'b0111, 1, 0, 0));
    exp_q.push_back(mk(76, 100, 60, 50, 4'b0111, 1, 0, 0));
    exp_q.push_back(mk(71, 100, 60, 50, 4'b0111, 1, 0, 0));
    exp_q.push_back(mk(66, 100, 60, 50, 4'b0111, 0, 0, 0));
    exp_q.push_back(mk(66, 100, 60, 50, 4'b0111, 0, 1, 0));
    exp_q.push_back(mk(66, 100, 60, 50, 4'b0111, 0, 0, 0));
    bus.cmd_ch    = 3'd0;
    bus.cmd_pos   = 7'd66;
    bus.cmd_valid = 1'b1;
    chk("tick_cycle_ready", 32'(bus.cmd_ready), 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("tick_sweep_ready", 32'(bus.cmd_ready), 0);
    @(negedge clk);
    chk("tick_first_step", 32'(pos_out[6:0]), 76);
    wait_drain("drain_tick");

    // Reset in the middle of a sweep
    wait_ready(1'b0, "abort_sweep");
    wait_ready(1'b1, "abort_idle");
    exp_q.push_back(mk(66, 100, 60, 10, 4'b1111, 0, 0, 0));
    send(3'd3, 7'd10);
    exp_q.push_back(mk(66, 100, 60, 10, 4'b1111, 1, 0, 0));
    send(3'd0, 7'd0);
    send(3'd1, 7'd0);
    send(3'd2, 7'd100);
    send(3'd3, 7'd100);
    exp_q.push_back(mk(61, 100, 60, 10, 4'b1111, 1, 0, 0));
    exp_q.push_back(mk(61, 95, 60, 10, 4'b1111, 1, 0, 0));
    exp_q.push_back(mk(50, 50, 50, 50, 4'b0000, 0, 0, 0));
    wait_ready(1'b0, "abort_start");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_ready", 32'(bus.cmd_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_post_ready", 32'(bus.cmd_ready), 1);
    repeat (30) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/servo_motion_scheduler.md
# servo_motion_scheduler

Multi-channel motion controller placed upstream of the arm's per-joint servo PWM generators. It accepts joint position commands over a valid/ready handshake and stores a target per channel. On every servo frame tick it ramps each channel's current position toward its target by at most STEP_SIZE. It presents the ramped positions and per-channel enables that drive the PWM blocks' data/en inputs.

## Interface
- NUM_CH, 4: number of servo channels (1..8).
- POS_W, 7: position word width; must satisfy 2^POS_W > POS_MAX.
- POS_MAX, 100: maximum legal position (0 = MIN_PULSE end, POS_MAX = MAX_PULSE end).
- POS_HOME, 50: reset position of every channel.
- STEP_SIZE, 5: maximum position change per channel per tick (≥1).
- UPDATE_CYCLES, 1_000_000: clk cycles per frame tick (≥ NUM_CH+2).
- CH_W, $clog2(NUM_CH) (min 1): channel index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  scheduler can accept a command.
- cmd_ch  in  CH_W  target channel index.
- cmd_pos  in  POS_W  requested position.
- cmd_err  out  1  one-cycle pulse: accepted command had cmd_ch ≥ NUM_CH.
- pos_out  out  NUM_CH*POS_W  current positions, channel k at bits [k*POS_W +: POS_W].
- ch_en  out  NUM_CH  channel enabled (has received at least one command).
- busy  out  1  some enabled channel has current ≠ target.
- move_done  out  1  one-cycle pulse when a move completes.

## Operation
- Registers per channel: cur[k], tgt[k], en[k]. pos_out mirrors cur, ch_en mirrors en.
- Frame counter runs 0..UPDATE_CYCLES-1 and wraps. tick is asserted when counter == UPDATE_CYCLES-1.
- FSM states:
  - IDLE: cmd_ready=1. On tick, go to SWEEP with idx=0.
  - SWEEP: cmd_ready=0. Spend one cycle per channel, idx 0..NUM_CH-1. After idx = NUM_CH-1, go to IDLE.
- Command accept occurs when cmd_valid && cmd_ready:
  - cmd_ch ≥ NUM_CH: pulse cmd_err next cycle. No other state change.
  - Otherwise, tgt[ch] ← min(cmd_pos, POS_MAX) (saturate).
  - If en[ch]=0: also set cur[ch] ← saturated pos and en[ch] ← 1. There is no ramp on first enable.
  - If en[ch]=1: cur[ch] is unchanged; the ramp proceeds on subsequent ticks.
- SWEEP step for channel idx, applied only when en[idx]=1:
  - cur < tgt: cur ← cur + min(STEP_SIZE, tgt-cur).
  - cur > tgt: cur ← cur - min(STEP_SIZE, cur-tgt).
  - Equal: no change.
  - Arithmetic is done in POS_W+1 bits. The result never overshoots tgt and never leaves [0, POS_MAX].
- busy = OR over k of (en[k] && cur[k] ≠ tgt[k]), decoded from registers.
- move_done pulses when busy was 1 at SWEEP entry and is 0 after the final SWEEP cycle.
- Disabled channels hold POS_HOME; the downstream PWM is gated by ch_en.

## Timing
- Reset values: cur=tgt=POS_HOME for all channels, en=0, counter=0, FSM=IDLE. Outputs: pos_out all POS_HOME, ch_en=0, busy=0, move_done=0, cmd_err=0.
- cmd_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
- Accept latency: tgt/cur/en update at the clock edge of the handshake, so they are visible the next cycle.
- Tick and accept in the same IDLE cycle: the command is applied first. SWEEP starts the next cycle and uses the new target.
- SWEEP lasts exactly NUM_CH cycles. cur[k] updates at the end of SWEEP cycle k.
- move_done is asserted in the cycle after the last SWEEP cycle. cmd_err is asserted in the cycle after the accept.
- The counter keeps running during SWEEP; ticks are never lost, because UPDATE_CYCLES > NUM_CH+1.
- rst asserted mid-SWEEP aborts the sweep. All state returns to reset values on that edge.

## Test plan
Unless stated otherwise, the bench uses UPDATE_CYCLES=10, NUM_CH=4, STEP_SIZE=5.
- Reset: after rst, pos_out = {50,50,50,50}, ch_en=0000, busy=0, cmd_ready=1 on the first post-reset cycle.
- First enable: cmd ch0 pos 80 → next cycle pos0=80, ch_en=0001, busy=0, with no ramp and no move_done.
- Ramp: ch0 at 80, cmd pos 93 → busy=1. After successive sweeps pos0 = 85, 90, 93. move_done pulses once after the third sweep, then busy=0. Down-ramp 93→81 gives 88, 83, 81.
- Saturation/error: cmd ch1 pos 120 → tgt1=100, cur1=100. cmd_ch=5 (with CH_W=3, NUM_CH=4) → cmd_err one pulse, and pos_out/ch_en are unchanged.
- Handshake: hold cmd_valid across a tick. cmd_ready=0 for exactly 4 cycles during SWEEP, the command is accepted on return to IDLE, and it is accepted only once. A command coincident with the tick is applied before that sweep.
- Reset mid-sweep: assert rst on SWEEP cycle 2 with ch0..3 moving → all pos_out=50, ch_en=0000, FSM IDLE, and no move_done pulse.
